// File: rtl/conv_pkg.sv
// Constants and types shared by the line buffer and the 3x3 convolution array.
package conv_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IMG_WIDTH  = 224;
  localparam int IMG_HEIGHT = 224;

  // 1: column packed as {row r-2, row r-1, row r} with row r-2 in the MSBs
  localparam bit TOP_MSB = 1'b1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/line_mem.sv
// One image row of pixel storage: combinational read, synchronous write, no reset.
module line_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 224,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // row storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_3row.sv
// Two-row line buffer turning a raster pixel stream into vertical 3-pixel columns
// for the convolution array.
module line_buffer_3row #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int IMG_WIDTH  = conv_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = conv_pkg::IMG_HEIGHT,
  localparam int XW        = $clog2(IMG_WIDTH),
  localparam int YW        = $clog2(IMG_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pix_valid,
  input  logic                    pix_sof,
  input  logic [DATA_WIDTH-1:0]   pix_data,
  output logic                    col_valid,
  output logic [3*DATA_WIDTH-1:0] col_data,
  output logic [XW-1:0]           col_x,
  output logic                    frame_done,
  output logic                    sof_err
);
  import conv_pkg::*;

  localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
  localparam logic [XW-1:0] X_ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 32'd1);
  localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};
  localparam logic [YW-1:0] Y_ONE  = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 32'd1);

  state_e                  state_r, state_nxt_s;
  logic [XW-1:0]           x_cnt_r, x_nxt_s, addr_s;
  logic [YW-1:0]           y_cnt_r, y_nxt_s;
  logic                    last_x_s, last_y_s, sof_bad_s, emit_s;
  logic [DATA_WIDTH-1:0]   l0_rd_s, l1_rd_s;
  logic [3*DATA_WIDTH-1:0] col_pack_s;
  logic                    col_valid_r, frame_done_r, sof_err_r;
  logic [3*DATA_WIDTH-1:0] col_data_r;
  logic [XW-1:0]           col_x_r;

  assign last_x_s  = (x_cnt_r == X_LAST);
  assign last_y_s  = (y_cnt_r == Y_LAST);
  assign sof_bad_s = pix_valid & pix_sof & ((x_cnt_r != X_ZERO) | (y_cnt_r != Y_ZERO));
  // a misplaced sof restarts the frame, so its pixel lands in column 0
  assign addr_s    = sof_bad_s ? X_ZERO : x_cnt_r;
  assign emit_s    = pix_valid & (state_r == STREAM) & ~sof_bad_s;
  assign col_pack_s = TOP_MSB ? {l0_rd_s, l1_rd_s, pix_data} : {pix_data, l1_rd_s, l0_rd_s};

  line_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(XW)) u_l0 (
    .clk(clk), .we(pix_valid), .addr(addr_s), .wdata(l1_rd_s), .rdata(l0_rd_s)
  );

  line_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .AW(XW)) u_l1 (
    .clk(clk), .we(pix_valid), .addr(addr_s), .wdata(pix_data), .rdata(l1_rd_s)
  );

  // raster position of the next pixel
  always_comb begin
    x_nxt_s = x_cnt_r;
    y_nxt_s = y_cnt_r;
    if (sof_bad_s) begin
      x_nxt_s = X_ONE;
      y_nxt_s = Y_ZERO;
    end else if (pix_valid) begin
      if (last_x_s) begin
        x_nxt_s = X_ZERO;
        if (last_y_s) begin
          y_nxt_s = Y_ZERO;
        end else begin
          y_nxt_s = y_cnt_r + Y_ONE;
        end
      end else begin
        x_nxt_s = x_cnt_r + X_ONE;
      end
    end else begin
      x_nxt_s = x_cnt_r;
    end
  end

  // frame phase: fill two rows, stream columns, one flush cycle
  always_comb begin
    state_nxt_s = state_r;
    if (sof_bad_s) begin
      state_nxt_s = FILL;
    end else begin
      case (state_r)
        FILL: begin
          if (pix_valid && last_x_s && (y_cnt_r == Y_ONE)) begin
            state_nxt_s = STREAM;
          end else begin
            state_nxt_s = FILL;
          end
        end
        STREAM: begin
          if (pix_valid && last_x_s && last_y_s) begin
            state_nxt_s = FLUSH;
          end else begin
            state_nxt_s = STREAM;
          end
        end
        FLUSH:   state_nxt_s = FILL;
        default: state_nxt_s = FILL;
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FILL;
      x_cnt_r      <= X_ZERO;
      y_cnt_r      <= Y_ZERO;
      col_valid_r  <= 1'b0;
      col_data_r   <= {(3*DATA_WIDTH){1'b0}};
      col_x_r      <= X_ZERO;
      frame_done_r <= 1'b0;
      sof_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      x_cnt_r      <= x_nxt_s;
      y_cnt_r      <= y_nxt_s;
      col_valid_r  <= emit_s;
      frame_done_r <= (state_r == FLUSH);
      sof_err_r    <= sof_bad_s;
      if (emit_s) begin
        col_data_r <= col_pack_s;
        col_x_r    <= x_cnt_r;
      end
    end
  end

  assign col_valid  = col_valid_r;
  assign col_data   = col_data_r;
  assign col_x      = col_x_r;
  assign frame_done = frame_done_r;
  assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row: a 4x4 instance for the directed scenarios
// and a default-size instance fed one random frame.
module tb_line_buffer_3row;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 224;
  localparam int BH = 224;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        pix_valid, pix_sof;
  logic [7:0]  pix_data;
  logic        col_valid, frame_done, sof_err;
  logic [23:0] col_data;
  logic [1:0]  col_x;

  logic        b_pix_valid, b_pix_sof;
  logic [7:0]  b_pix_data;
  logic        b_col_valid, b_frame_done, b_sof_err;
  logic [23:0] b_col_data;
  logic [7:0]  b_col_x;

  int n_vec = 0;
  int n_err = 0;
  logic [25:0] exp_q[$];
  logic [31:0] bexp_q[$];
  logic [7:0]  img [BH][BW];

  line_buffer_3row #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .col_valid(col_valid), .col_data(col_data), .col_x(col_x),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  line_buffer_3row dut_big (
    .clk(clk), .rst(rst), .pix_valid(b_pix_valid), .pix_sof(b_pix_sof), .pix_data(b_pix_data),
    .col_valid(b_col_valid), .col_data(b_col_data), .col_x(b_col_x),
    .frame_done(b_frame_done), .sof_err(b_sof_err)
  );

  // expected column for pixel (x,y) of a frame whose pixels are base + 16*y + x
  function automatic logic [25:0] col_of(int x, int y, logic [7:0] base);
    logic [7:0] a, b, c;
    a = base + 8'(16 * (y - 2) + x);
    b = base + 8'(16 * (y - 1) + x);
    c = base + 8'(16 * y + x);
    return {a, b, c, 2'(x)};
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic bstep(input logic v, input logic s, input logic [7:0] d);
    b_pix_valid = v;
    b_pix_sof   = s;
    b_pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 8'h00;
    b_pix_valid = 1'b0; b_pix_sof = 1'b0; b_pix_data = 8'h00;
    #3;
    n_vec++;
    if ({col_valid, col_data, col_x, frame_done, sof_err} !== 29'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h x=%0d fd=%b se=%b want all 0",
               col_valid, col_data, col_x, frame_done, sof_err);
    end
    n_vec++;
    if (b_col_valid !== 1'b0 || b_frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_big: got v=%b fd=%b want 0 0", b_col_valid, b_frame_done);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame(input string name);
    int beats;
    logic [25:0] e;
    beats = 0;
    for (int p = 0; p < 18; p++) begin
      int x, y;
      logic fd_exp;
      x = p % W; y = p / W; fd_exp = (p == 16);
      if (p < 16) begin
        if (y >= 2) exp_q.push_back(col_of(x, y, 8'h00));
        step(1'b1, p == 0, 8'(16 * y + x));
      end else begin
        step(1'b0, 1'b0, 8'h00);
      end
      n_vec++;
      if (col_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL %s col_valid p=%0d: got %b want %b", name, p, col_valid, exp_q.size() != 0);
        exp_q.delete();
      end else if (col_valid === 1'b1) begin
        e = exp_q.pop_front();
        beats++;
        n_vec++;
        if ({col_data, col_x} !== e) begin
          n_err++;
          $display("FAIL %s col p=%0d: got %h x=%0d want %h x=%0d", name, p, col_data, col_x, e[25:2], e[1:0]);
        end
      end
      n_vec++;
      if (frame_done !== fd_exp || sof_err !== 1'b0) begin
        n_err++;
        $display("FAIL %s flags p=%0d: got fd=%b se=%b want fd=%b se=0", name, p, frame_done, sof_err, fd_exp);
      end
    end
    n_vec++;
    if (beats != 8) begin
      n_err++;
      $display("FAIL %s beat_count: got %0d want 8", name, beats);
    end
  endtask

  task automatic test_gaps();
    int beats;
    logic [25:0] e;
    beats = 0;
    for (int q = 0; q < 34; q++) begin
      int p, x, y;
      logic fd_exp;
      p = q / 2; x = p % W; y = p / W; fd_exp = (q == 31);
      if (q % 2 == 0 && p < 16) begin
        if (y >= 2) exp_q.push_back(col_of(x, y, 8'h00));
        step(1'b1, p == 0, 8'(16 * y + x));
      end else begin
        step(1'b0, 1'b0, 8'hEE);
      end
      n_vec++;
      if (col_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL gaps col_valid q=%0d: got %b want %b", q, col_valid, exp_q.size() != 0);
        exp_q.delete();
      end else if (col_valid === 1'b1) begin
        e = exp_q.pop_front();
        beats++;
        n_vec++;
        if ({col_data, col_x} !== e) begin
          n_err++;
          $display("FAIL gaps col q=%0d: got %h x=%0d want %h x=%0d", q, col_data, col_x, e[25:2], e[1:0]);
        end
      end
      n_vec++;
      if (frame_done !== fd_exp) begin
        n_err++;
        $display("FAIL gaps frame_done q=%0d: got %b want %b", q, frame_done, fd_exp);
      end
    end
    n_vec++;
    if (beats != 8) begin
      n_err++;
      $display("FAIL gaps beat_count: got %0d want 8", beats);
    end
  endtask

  task automatic test_back_to_back();
    int beats;
    logic [25:0] e;
    beats = 0;
    for (int k = 0; k < 34; k++) begin
      int p, x, y;
      logic fd_exp;
      p = k % 16; x = p % W; y = p / W; fd_exp = (k == 16) || (k == 32);
      if (k < 32) begin
        if (y >= 2) exp_q.push_back(col_of(x, y, 8'h00));
        step(1'b1, p == 0, 8'(16 * y + x));
      end else begin
        step(1'b0, 1'b0, 8'h00);
      end
      n_vec++;
      if (col_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL b2b col_valid k=%0d: got %b want %b", k, col_valid, exp_q.size() != 0);
        exp_q.delete();
      end else if (col_valid === 1'b1) begin
        e = exp_q.pop_front();
        beats++;
        n_vec++;
        if ({col_data, col_x} !== e) begin
          n_err++;
          $display("FAIL b2b col k=%0d: got %h x=%0d want %h x=%0d", k, col_data, col_x, e[25:2], e[1:0]);
        end
      end
      n_vec++;
      if (frame_done !== fd_exp || sof_err !== 1'b0) begin
        n_err++;
        $display("FAIL b2b flags k=%0d: got fd=%b se=%b want fd=%b se=0", k, frame_done, sof_err, fd_exp);
      end
    end
    n_vec++;
    if (beats != 16) begin
      n_err++;
      $display("FAIL b2b beat_count: got %0d want 16", beats);
    end
  endtask

  task automatic test_sof_err();
    int beats;
    logic [25:0] e;
    beats = 0;
    // k 0..9: aborted frame (base 0x80); k 10: sof at (2,2); k 11..25: rest of new frame
    for (int k = 0; k < 28; k++) begin
      int p, x, y;
      logic fd_exp, se_exp;
      fd_exp = (k == 26); se_exp = (k == 10);
      if (k < 10) begin
        x = k % W; y = k / W;
        if (y >= 2) exp_q.push_back(col_of(x, y, 8'h80));
        step(1'b1, k == 0, 8'h80 + 8'(16 * y + x));
      end else if (k < 26) begin
        p = k - 10; x = p % W; y = p / W;
        if (y >= 2) exp_q.push_back(col_of(x, y, 8'h00));
        step(1'b1, k == 10, 8'(16 * y + x));
      end else begin
        step(1'b0, 1'b0, 8'h00);
      end
      n_vec++;
      if (col_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL sof col_valid k=%0d: got %b want %b", k, col_valid, exp_q.size() != 0);
        exp_q.delete();
      end else if (col_valid === 1'b1) begin
        e = exp_q.pop_front();
        beats++;
        n_vec++;
        if ({col_data, col_x} !== e) begin
          n_err++;
          $display("FAIL sof col k=%0d: got %h x=%0d want %h x=%0d", k, col_data, col_x, e[25:2], e[1:0]);
        end
      end
      n_vec++;
      if (frame_done !== fd_exp || sof_err !== se_exp) begin
        n_err++;
        $display("FAIL sof flags k=%0d: got fd=%b se=%b want fd=%b se=%b", k, frame_done, sof_err, fd_exp, se_exp);
      end
    end
    n_vec++;
    if (beats != 10) begin
      n_err++;
      $display("FAIL sof beat_count: got %0d want 10", beats);
    end
  endtask

  task automatic test_reset_midframe();
    logic [25:0] e;
    for (int k = 0; k < 9; k++) begin
      int x, y;
      x = k % W; y = k / W;
      if (y >= 2) exp_q.push_back(col_of(x, y, 8'h00));
      step(1'b1, k == 0, 8'(16 * y + x));
      n_vec++;
      if (col_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL rstmid col_valid k=%0d: got %b want %b", k, col_valid, exp_q.size() != 0);
        exp_q.delete();
      end else if (col_valid === 1'b1) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({col_data, col_x} !== e) begin
          n_err++;
          $display("FAIL rstmid col k=%0d: got %h x=%0d want %h x=%0d", k, col_data, col_x, e[25:2], e[1:0]);
        end
      end
    end
    #1;
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    #1;
    n_vec++;
    if ({col_valid, col_data, col_x, frame_done, sof_err} !== 29'd0) begin
      n_err++;
      $display("FAIL rstmid outputs: got v=%b d=%h x=%0d fd=%b se=%b want all 0",
               col_valid, col_data, col_x, frame_done, sof_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_full_frame("after_rst");
  endtask

  task automatic test_big_random();
    int beats;
    logic [31:0] e;
    logic [7:0]  d;
    beats = 0;
    for (int k = 0; k < BW * BH + 2; k++) begin
      int x, y;
      logic fd_exp;
      x = k % BW; y = k / BW; fd_exp = (k == BW * BH);
      if (k < BW * BH) begin
        d = 8'($urandom_range(0, 255));
        img[y][x] = d;
        if (y >= 2) bexp_q.push_back({img[y-2][x], img[y-1][x], d, 8'(x)});
        bstep(1'b1, k == 0, d);
      end else begin
        bstep(1'b0, 1'b0, 8'h00);
      end
      n_vec++;
      if (b_col_valid !== (bexp_q.size() != 0)) begin
        n_err++;
        if (n_err < 20) $display("FAIL big col_valid k=%0d: got %b want %b", k, b_col_valid, bexp_q.size() != 0);
        bexp_q.delete();
      end else if (b_col_valid === 1'b1) begin
        e = bexp_q.pop_front();
        beats++;
        n_vec++;
        if ({b_col_data, b_col_x} !== e) begin
          n_err++;
          if (n_err < 20) $display("FAIL big col k=%0d: got %h x=%0d want %h x=%0d", k, b_col_data, b_col_x, e[31:8], e[7:0]);
        end
      end
      n_vec++;
      if (b_frame_done !== fd_exp || b_sof_err !== 1'b0) begin
        n_err++;
        if (n_err < 20) $display("FAIL big flags k=%0d: got fd=%b se=%b want fd=%b se=0", k, b_frame_done, b_sof_err, fd_exp);
      end
    end
    n_vec++;
    if (beats != (BH - 2) * BW) begin
      n_err++;
      $display("FAIL big beat_count: got %0d want %0d", beats, (BH - 2) * BW);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame("full");
    test_gaps();
    test_back_to_back();
    test_sof_err();
    test_reset_midframe();
    test_big_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
